// File: rtl/tl_pkg.sv
// tl_pkg: lamp/state encodings and default timer intervals for traffic_ctrl
package tl_pkg;
  typedef enum logic [1:0] {HG = 2'd0, HY = 2'd1, FG = 2'd2, FY = 2'd3} state_t;
  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;
  localparam logic [3:0] T_BASE = 4'd5;
  localparam logic [3:0] T_EXT = 4'd3;
  localparam logic [3:0] T_YEL = 4'd1;
  function automatic logic [3:0] lamps(input state_t s);
    return s == HG ? {GRN, RED} : s == HY ? {YEL, RED} : s == FG ? {RED, GRN} : {RED, YEL};
  endfunction
endpackage

// File: rtl/sensor_sync.sv
// sensor_sync: 2-flop synchronizer for the farm sensor plus a set/clear request latch
module sensor_sync (
  input  logic clk,
  input  logic reset_sync,
  input  logic sensor,
  input  logic clr,
  output logic sens_s,
  output logic req
);
  logic r_s1, r_s2, r_req;
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_req <= 1'b0;
    end else begin
      r_s1 <= sensor;
      r_s2 <= r_s1;
      r_req <= !clr && (r_req || r_s2);
    end
  end
  assign sens_s = r_s2;
  assign req = r_req;
endmodule

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: highway/farm intersection FSM driving a countdown timer
module traffic_ctrl
  import tl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_sync,
  input  logic       sensor,
  input  logic       expired,
  output logic       start_t,
  output logic [3:0] tp_val,
  output logic [1:0] hw_light,
  output logic [1:0] fr_light,
  output logic [1:0] phase
);
  state_t r_state, w_next;
  logic [3:0] r_tp, w_tp, w_lamps;
  logic [1:0] r_hw, r_fr;
  logic r_start, r_guard, r_boot, r_min_done, r_ext_used;
  logic w_start, w_set_ext, w_exp, w_sens_s, w_req, w_clr;
  // expiry pulses are untrustworthy while the timer is being restarted
  assign w_exp = expired && !r_start && !r_guard;
  assign w_clr = r_state == FG || w_next == FG;
  sensor_sync u_sync (
    .clk(clk),
    .reset_sync(reset_sync),
    .sensor(sensor),
    .clr(w_clr),
    .sens_s(w_sens_s),
    .req(w_req)
  );
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      r_state <= HG;
      r_tp <= T_BASE;
      r_start <= 1'b0;
      r_guard <= 1'b0;
      r_boot <= 1'b1;
      r_min_done <= 1'b0;
      r_ext_used <= 1'b0;
      r_hw <= GRN;
      r_fr <= RED;
    end else begin
      r_state <= w_next;
      r_tp <= w_tp;
      r_start <= w_start || r_boot;
      r_guard <= r_start;
      r_boot <= 1'b0;
      r_min_done <= (r_state == FY && w_exp) ? 1'b0 : r_min_done || (r_state == HG && w_exp);
      r_ext_used <= (r_state == HY && w_exp) ? 1'b0 : r_ext_used || w_set_ext;
      {r_hw, r_fr} <= w_lamps;
    end
  end
  always_comb begin
    w_next = r_state;
    w_tp = r_tp;
    w_start = 1'b0;
    w_set_ext = 1'b0;
    case (r_state)
      HG: if ((r_min_done || w_exp) && (w_req || w_sens_s)) begin
        w_next = HY;
        w_tp = T_YEL;
        w_start = 1'b1;
      end
      HY: if (w_exp) begin
        w_next = FG;
        w_tp = T_BASE;
        w_start = 1'b1;
      end
      FG: if (w_exp) begin
        w_next = (w_sens_s && !r_ext_used) ? FG : FY;
        w_tp = (w_sens_s && !r_ext_used) ? T_EXT : T_YEL;
        w_set_ext = w_sens_s && !r_ext_used;
        w_start = 1'b1;
      end
      FY: if (w_exp) begin
        w_next = HG;
        w_tp = T_BASE;
        w_start = 1'b1;
      end
    endcase
  end
  always_comb w_lamps = lamps(w_next);
  assign start_t = r_start;
  assign tp_val = r_tp;
  assign hw_light = r_hw;
  assign fr_light = r_fr;
  assign phase = r_state;
endmodule
